// File: rtl/multi_singly_linked_list.sv
// multi_singly_linked_list: NUM_LISTS singly linked lists sharing one node pool, one operation at a time
module multi_singly_linked_list #(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_NODE   = 8,
   parameter int NUM_LISTS  = 4,
   localparam int PTR_W  = $clog2(MAX_NODE + 1),
   localparam int LSEL_W = (NUM_LISTS > 1) ? $clog2(NUM_LISTS) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       op_start,
   input  logic [2:0]                 op,
   input  logic [LSEL_W-1:0]          list_sel,
   input  logic [PTR_W-1:0]           idx_in,
   input  logic [DATA_WIDTH-1:0]      data_in,
   output logic                       op_ready,
   output logic                       op_done,
   output logic                       fault,
   output logic [DATA_WIDTH-1:0]      data_out,
   output logic [PTR_W-1:0]           addr_out,
   output logic [NUM_LISTS*PTR_W-1:0] length_flat,
   output logic [NUM_LISTS-1:0]       list_empty,
   output logic [PTR_W-1:0]           free_count,
   output logic                       full
);
   localparam int AW = (MAX_NODE > 1) ? $clog2(MAX_NODE) : 1;
   localparam logic [PTR_W-1:0] NIL = {PTR_W{1'b1}};

   typedef enum logic [2:0] {OP_READ, OP_INS, OP_DELV, OP_DELI, OP_PUSHB, OP_PUSHF, OP_POP, OP_CLR} op_e;
   typedef enum logic [2:0] {S_IDLE, S_EXEC, S_WALK, S_FIND, S_CLEAR, S_DONE} state_e;

   state_e                state_q, state_d;
   op_e                   op_q, op_d;
   logic [LSEL_W-1:0]     lsel_q, lsel_d;
   logic [PTR_W-1:0]      idx_q, idx_d, cur_q, cur_d, prev_q, prev_d, cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] din_q, din_d, dout_q, dout_d;
   logic [PTR_W-1:0]      aout_q, aout_d;
   logic                  fault_q, fault_d;
   logic [MAX_NODE-1:0]   vld_q, vld_d;
   logic [PTR_W-1:0]      nxt_q [MAX_NODE];
   logic [PTR_W-1:0]      nxt_d [MAX_NODE];
   logic [DATA_WIDTH-1:0] mem_q [MAX_NODE];
   logic [DATA_WIDTH-1:0] mem_d [MAX_NODE];
   logic [PTR_W-1:0]      head_q [NUM_LISTS];
   logic [PTR_W-1:0]      head_d [NUM_LISTS];
   logic [PTR_W-1:0]      tail_q [NUM_LISTS];
   logic [PTR_W-1:0]      tail_d [NUM_LISTS];
   logic [PTR_W-1:0]      len_q [NUM_LISTS];
   logic [PTR_W-1:0]      len_d [NUM_LISTS];

   logic [PTR_W-1:0]  fp, fc, hd, tl, ln;
   logic [LSEL_W-1:0] ls, isel;
   logic              lsel_ok, ins_f, ins_b, ins_m, del;

   function automatic logic [AW-1:0] ix(input logic [PTR_W-1:0] p);
      return AW'(p);
   endfunction

   assign lsel_ok = 32'(lsel_q) < NUM_LISTS;
   assign ls      = lsel_ok ? lsel_q : '0;
   assign isel    = (32'(list_sel) < NUM_LISTS) ? list_sel : '0;
   assign hd      = head_q[ls];
   assign tl      = tail_q[ls];
   assign ln      = len_q[ls];

   // lowest free pool slot and number of free slots
   always_comb begin
      fp = NIL;
      fc = '0;
      for (int i = MAX_NODE - 1; i >= 0; i--) begin
         if (!vld_q[i]) fp = PTR_W'(i);
         fc = fc + PTR_W'(!vld_q[i]);
      end
   end

   // next state, list walk and the single commit of each insert/delete
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      lsel_d  = lsel_q;
      idx_d   = idx_q;
      din_d   = din_q;
      cur_d   = cur_q;
      prev_d  = prev_q;
      cnt_d   = cnt_q;
      fault_d = fault_q;
      dout_d  = dout_q;
      aout_d  = aout_q;
      vld_d   = vld_q;
      nxt_d   = nxt_q;
      mem_d   = mem_q;
      head_d  = head_q;
      tail_d  = tail_q;
      len_d   = len_q;
      ins_f   = 1'b0;
      ins_b   = 1'b0;
      ins_m   = 1'b0;
      del     = 1'b0;
      case (state_q)
         S_IDLE: if (op_start) begin
            op_d    = op_e'(op);
            lsel_d  = list_sel;
            idx_d   = idx_in;
            din_d   = data_in;
            cur_d   = head_q[isel];
            prev_d  = NIL;
            cnt_d   = '0;
            fault_d = 1'b0;
            state_d = (op_e'(op) inside {OP_PUSHB, OP_PUSHF, OP_POP}) ? S_EXEC :
                      (op_e'(op) == OP_DELV) ? S_FIND : (op_e'(op) == OP_CLR) ? S_CLEAR : S_WALK;
         end
         S_EXEC: begin
            state_d = S_DONE;
            if (!lsel_ok || ((op_q == OP_POP) ? (ln == '0) : full)) fault_d = 1'b1;
            else begin
               ins_b = op_q == OP_PUSHB;
               ins_f = op_q == OP_PUSHF;
               del   = op_q == OP_POP;
            end
         end
         S_WALK: begin
            if (cnt_q == '0 && (!lsel_ok || ((op_q == OP_INS) ? full : (idx_q >= ln)))) begin
               fault_d = 1'b1;
               state_d = S_DONE;
            end else if (cnt_q == idx_q || (op_q == OP_INS && idx_q >= ln)) begin
               state_d = S_DONE;
               ins_b   = op_q == OP_INS && idx_q >= ln;
               ins_f   = op_q == OP_INS && idx_q < ln && idx_q == '0;
               ins_m   = op_q == OP_INS && idx_q < ln && idx_q != '0;
               del     = op_q == OP_DELI;
               if (op_q == OP_READ) begin
                  dout_d = mem_q[ix(cur_q)];
                  aout_d = cur_q;
               end
            end else begin
               prev_d = cur_q;
               cur_d  = nxt_q[ix(cur_q)];
               cnt_d  = cnt_q + 1'b1;
            end
         end
         S_FIND: begin
            if (!lsel_ok || cur_q == NIL) begin
               fault_d = 1'b1;
               state_d = S_DONE;
            end else if (mem_q[ix(cur_q)] == din_q) begin
               del     = 1'b1;
               state_d = S_DONE;
            end else begin
               prev_d = cur_q;
               cur_d  = nxt_q[ix(cur_q)];
            end
         end
         S_CLEAR: begin
            if (!lsel_ok) begin
               fault_d = 1'b1;
               state_d = S_DONE;
            end else if (hd == NIL) state_d = S_DONE;
            else begin
               vld_d[ix(hd)] = 1'b0;
               nxt_d[ix(hd)] = NIL;
               head_d[ls]    = nxt_q[ix(hd)];
               len_d[ls]     = ln - 1'b1;
               if (nxt_q[ix(hd)] == NIL) tail_d[ls] = NIL;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (ins_f || ins_b || ins_m) begin
         vld_d[ix(fp)] = 1'b1;
         mem_d[ix(fp)] = din_q;
         nxt_d[ix(fp)] = ins_f ? hd : ins_m ? cur_q : NIL;
         len_d[ls]     = ln + 1'b1;
         aout_d        = fp;
         if (ins_f) head_d[ls] = fp;
         if ((ins_f && hd == NIL) || ins_b) tail_d[ls] = fp;
         if (ins_b && tl == NIL) head_d[ls] = fp;
         if (ins_b && tl != NIL) nxt_d[ix(tl)] = fp;
         if (ins_m) nxt_d[ix(prev_q)] = fp;
      end
      if (del) begin
         vld_d[ix(cur_q)] = 1'b0;
         nxt_d[ix(cur_q)] = NIL;
         len_d[ls]        = ln - 1'b1;
         dout_d           = mem_q[ix(cur_q)];
         aout_d           = cur_q;
         if (prev_q == NIL) head_d[ls] = nxt_q[ix(cur_q)];
         else nxt_d[ix(prev_q)] = nxt_q[ix(cur_q)];
         if (cur_q == tl) tail_d[ls] = prev_q;
      end
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else state_q <= state_d;
   end

   // operation context, walk pointers, node pool and list descriptors
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q    <= OP_READ;
         lsel_q  <= '0;
         idx_q   <= '0;
         din_q   <= '0;
         cur_q   <= NIL;
         prev_q  <= NIL;
         cnt_q   <= '0;
         fault_q <= 1'b0;
         dout_q  <= '0;
         aout_q  <= '0;
         vld_q   <= '0;
         nxt_q   <= '{default: NIL};
         mem_q   <= '{default: '0};
         head_q  <= '{default: NIL};
         tail_q  <= '{default: NIL};
         len_q   <= '{default: '0};
      end else begin
         op_q    <= op_d;
         lsel_q  <= lsel_d;
         idx_q   <= idx_d;
         din_q   <= din_d;
         cur_q   <= cur_d;
         prev_q  <= prev_d;
         cnt_q   <= cnt_d;
         fault_q <= fault_d;
         dout_q  <= dout_d;
         aout_q  <= aout_d;
         vld_q   <= vld_d;
         nxt_q   <= nxt_d;
         mem_q   <= mem_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         len_q   <= len_d;
      end
   end

   assign op_ready   = state_q == S_IDLE;
   assign op_done    = state_q == S_DONE;
   assign fault      = op_done & fault_q;
   assign data_out   = dout_q;
   assign addr_out   = aout_q;
   assign free_count = fc;
   assign full       = fc == '0;

   for (genvar g = 0; g < NUM_LISTS; g++) begin : g_stat
      assign length_flat[g*PTR_W +: PTR_W] = len_q[g];
      assign list_empty[g]                 = len_q[g] == '0;
   end
endmodule

// File: tb/tb_multi_singly_linked_list.sv
// tb_multi_singly_linked_list: directed vector table plus hand-written handshake and reset sequences
module tb_multi_singly_linked_list;
   localparam int DW = 8, MN = 8, NL = 2, PW = 4;
   localparam int RD = 0, IN = 1, DV = 2, DI = 3, PB = 4, PF = 5, PO = 6, CL = 7;

   typedef struct {
      int op, ls, idx, din, lat, flt, dout, aout, l0, l1, fc;
   } vec_t;

   logic          clk = 1'b0, rst = 1'b1, op_start = 1'b0;
   logic [2:0]    op = '0;
   logic          list_sel = 1'b0;
   logic [PW-1:0] idx_in = '0;
   logic [DW-1:0] data_in = '0;
   logic          op_ready, op_done, fault, full;
   logic [DW-1:0] data_out;
   logic [PW-1:0] addr_out, free_count;
   logic [NL*PW-1:0] length_flat;
   logic [NL-1:0] list_empty;

   int total = 0, bad = 0, done_cnt = 0;
   vec_t v[$];

   multi_singly_linked_list #(.DATA_WIDTH(DW), .MAX_NODE(MN), .NUM_LISTS(NL)) dut (
      .clk(clk), .rst(rst), .op_start(op_start), .op(op), .list_sel(list_sel),
      .idx_in(idx_in), .data_in(data_in), .op_ready(op_ready), .op_done(op_done),
      .fault(fault), .data_out(data_out), .addr_out(addr_out), .length_flat(length_flat),
      .list_empty(list_empty), .free_count(free_count), .full(full)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (op_done) done_cnt++;

   always @(negedge clk) if (!rst) begin
      total++;
      if (int'(length_flat[3:0]) + int'(length_flat[7:4]) + int'(free_count) != MN) begin
         bad++;
         $display("FAIL invariant: len0=%0d len1=%0d free=%0d, sum must be %0d",
                  length_flat[3:0], length_flat[7:4], free_count, MN);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_ready"}, op_ready, 1);
      chk({tag, "_done"}, op_done, 0);
      chk({tag, "_fault"}, fault, 0);
      chk({tag, "_dout"}, data_out, 0);
      chk({tag, "_aout"}, addr_out, 0);
      chk({tag, "_len"}, length_flat, 0);
      chk({tag, "_empty"}, list_empty, 2'b11);
      chk({tag, "_free"}, free_count, MN);
      chk({tag, "_full"}, full, 0);
   endtask

   task automatic run_op(input int o, input int ls, input int ix, input int d, output int lat);
      int n = 0;
      while (!op_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      op = 3'(o);
      list_sel = 1'(ls);
      idx_in = 4'(ix);
      data_in = 8'(d);
      op_start = 1'b1;
      @(negedge clk);
      op_start = 1'b0;
      op = 3'(o ^ 3);
      idx_in = 4'hF;
      data_in = 8'hA5;
      lat = 1;
      while (!op_done && lat < 100) begin
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      int lat, done0;
      //            op ls idx din  lat flt dout  aout l0 l1 fc
      v.push_back('{PB, 0, 0, 'h11, 2, 0, 'h00, 0, 1, 0, 7});
      v.push_back('{PB, 0, 0, 'h22, 2, 0, 'h00, 1, 2, 0, 6});
      v.push_back('{PB, 0, 0, 'h33, 2, 0, 'h00, 2, 3, 0, 5});
      v.push_back('{RD, 0, 1, 'h00, 3, 0, 'h22, 1, 3, 0, 5});
      v.push_back('{PF, 1, 0, 'hAA, 2, 0, 'h22, 3, 3, 1, 4});
      v.push_back('{DI, 0, 1, 'h00, 3, 0, 'h22, 1, 2, 1, 5});
      v.push_back('{PB, 1, 0, 'hBB, 2, 0, 'h22, 1, 2, 2, 4});
      v.push_back('{RD, 1, 1, 'h00, 3, 0, 'hBB, 1, 2, 2, 4});
      v.push_back('{PB, 0, 0, 'h44, 2, 0, 'hBB, 4, 3, 2, 3});
      v.push_back('{PB, 1, 0, 'hCC, 2, 0, 'hBB, 5, 3, 3, 2});
      v.push_back('{PF, 0, 0, 'h05, 2, 0, 'hBB, 6, 4, 3, 1});
      v.push_back('{IN, 1, 1, 'hDD, 3, 0, 'hBB, 7, 4, 4, 0});
      v.push_back('{IN, 0, 2, 'hEE, 2, 1, 'hBB, 7, 4, 4, 0});
      v.push_back('{PB, 1, 0, 'h99, 2, 1, 'hBB, 7, 4, 4, 0});
      v.push_back('{PO, 1, 0, 'h00, 2, 0, 'hAA, 3, 4, 3, 1});
      v.push_back('{RD, 1, 1, 'h00, 3, 0, 'hBB, 1, 4, 3, 1});
      v.push_back('{RD, 1, 3, 'h00, 2, 1, 'hBB, 1, 4, 3, 1});
      v.push_back('{DI, 0, 4, 'h00, 2, 1, 'hBB, 1, 4, 3, 1});
      v.push_back('{DV, 1, 0, 'h55, 5, 1, 'hBB, 1, 4, 3, 1});
      v.push_back('{DV, 1, 0, 'hCC, 4, 0, 'hCC, 5, 4, 2, 2});
      v.push_back('{PB, 1, 0, 'h77, 2, 0, 'hCC, 3, 4, 3, 1});
      v.push_back('{RD, 1, 2, 'h00, 4, 0, 'h77, 3, 4, 3, 1});
      v.push_back('{PO, 0, 0, 'h00, 2, 0, 'h05, 6, 3, 3, 2});
      v.push_back('{CL, 0, 0, 'h00, 5, 0, 'h05, 6, 0, 3, 5});
      v.push_back('{RD, 1, 0, 'h00, 2, 0, 'hDD, 7, 0, 3, 5});
      v.push_back('{RD, 1, 2, 'h00, 4, 0, 'h77, 3, 0, 3, 5});
      v.push_back('{CL, 0, 0, 'h00, 2, 0, 'h77, 3, 0, 3, 5});
      v.push_back('{PO, 0, 0, 'h00, 2, 1, 'h77, 3, 0, 3, 5});
      v.push_back('{DV, 0, 0, 'h11, 2, 1, 'h77, 3, 0, 3, 5});
      v.push_back('{IN, 0, 5, 'h42, 2, 0, 'h77, 0, 1, 3, 4});
      v.push_back('{IN, 0, 0, 'h41, 2, 0, 'h77, 2, 2, 3, 3});
      v.push_back('{DV, 0, 0, 'h41, 2, 0, 'h41, 2, 1, 3, 4});
      v.push_back('{DI, 0, 0, 'h00, 2, 0, 'h42, 0, 0, 3, 5});
      v.push_back('{PB, 0, 0, 'h10, 2, 0, 'h42, 0, 1, 3, 4});
      v.push_back('{RD, 0, 0, 'h00, 2, 0, 'h10, 0, 1, 3, 4});

      repeat (2) @(negedge clk);
      chk_reset("por");
      rst = 1'b0;
      @(negedge clk);

      foreach (v[i]) begin
         run_op(v[i].op, v[i].ls, v[i].idx, v[i].din, lat);
         chk($sformatf("v%0d_lat", i), lat, v[i].lat);
         chk($sformatf("v%0d_fault", i), fault, v[i].flt);
         chk($sformatf("v%0d_dout", i), data_out, v[i].dout);
         chk($sformatf("v%0d_aout", i), addr_out, v[i].aout);
         chk($sformatf("v%0d_len0", i), length_flat[3:0], v[i].l0);
         chk($sformatf("v%0d_len1", i), length_flat[7:4], v[i].l1);
         chk($sformatf("v%0d_free", i), free_count, v[i].fc);
         chk($sformatf("v%0d_empty", i), list_empty, {v[i].l1 == 0, v[i].l0 == 0});
         chk($sformatf("v%0d_full", i), full, v[i].fc == 0);
         @(negedge clk);
         chk($sformatf("v%0d_pulse", i), op_done, 0);
      end

      rst = 1'b1;
      @(negedge clk);
      chk_reset("rst2");
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 7; i++) begin
         run_op(PB, 0, 0, 'h60 + i, lat);
         chk($sformatf("fill%0d_aout", i), addr_out, i);
         @(negedge clk);
      end

      done0 = done_cnt;
      op = 3'(RD);
      list_sel = 1'b0;
      idx_in = 4'd5;
      op_start = 1'b1;
      @(negedge clk);
      op = 3'(PB);
      data_in = 8'hEE;
      lat = 1;
      repeat (3) begin
         @(negedge clk);
         lat++;
      end
      op_start = 1'b0;
      while (!op_done && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk("busy_lat", lat, 7);
      chk("busy_dout", data_out, 'h65);
      chk("busy_aout", addr_out, 5);
      chk("busy_fault", fault, 0);
      repeat (3) @(negedge clk);
      chk("busy_one_done", done_cnt - done0, 1);
      chk("busy_len0", length_flat[3:0], 7);
      chk("busy_free", free_count, 1);

      op = 3'(RD);
      idx_in = 4'd5;
      op_start = 1'b1;
      @(negedge clk);
      op_start = 1'b0;
      repeat (2) @(negedge clk);
      chk("walk_busy", op_ready, 0);
      rst = 1'b1;
      #1;
      chk_reset("mid");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", op_ready, 1);
      chk("post_rst_done", op_done, 0);
      run_op(PB, 0, 0, 'h99, lat);
      chk("post_rst_lat", lat, 2);
      chk("post_rst_aout", addr_out, 0);
      chk("post_rst_len0", length_flat[3:0], 1);
      chk("post_rst_free", free_count, 7);
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
